// File: rtl/msrv32_wb_port_arbiter.sv
// Shares the integer register file write port between the WB pipeline stage (priority)
// and a FIFO of long-latency-unit results. Optional starvation guard: WB_STARVE_GUARD_EN.
module msrv32_wb_port_arbiter #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     flush_in,
  input  logic                     rf_wr_en_reg_in,
  input  logic [4:0]               rd_addr_reg_in,
  input  logic [31:0]              rd_data_reg_in,
  input  logic                     lu_valid_in,
  input  logic [4:0]               lu_rd_addr_in,
  input  logic [31:0]              lu_data_in,
  output logic                     lu_ready_out,
  output logic                     wr_en_integer_file_out,
  output logic [4:0]               wr_addr_out,
  output logic [31:0]              wr_data_out,
  output logic                     stall_out,
  output logic [$clog2(DEPTH):0]   lu_pending_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [4:0]    r_mem_addr [DEPTH];
  logic [31:0]   r_mem_data [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_stall;
  logic w_pipe_wr;
  logic w_pop;
  logic w_push;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pipe_wr = ~rst_in & rf_wr_en_reg_in & ~flush_in & ~w_stall;
  assign w_pop     = ~rst_in & ~w_pipe_wr & ~w_empty;

  // Ready comes from the registered count only, so a full FIFO never pushes on a pop cycle.
  assign lu_ready_out   = ~rst_in & ~w_full;
  assign w_push         = lu_valid_in & lu_ready_out;
  assign lu_pending_out = r_count;
  assign stall_out      = w_stall;

  // Write port select: pipeline first, FIFO head in idle slots; x0 writes keep the slot.
  always_comb begin
    wr_en_integer_file_out = 1'b0;
    wr_addr_out            = '0;
    wr_data_out            = '0;
    if (w_pipe_wr) begin
      wr_en_integer_file_out = (rd_addr_reg_in != 5'd0);
      wr_addr_out            = rd_addr_reg_in;
      wr_data_out            = rd_data_reg_in;
    end else if (w_pop) begin
      wr_en_integer_file_out = (r_mem_addr[r_rptr] != 5'd0);
      wr_addr_out            = r_mem_addr[r_rptr];
      wr_data_out            = r_mem_data[r_rptr];
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem_addr[r_wptr] <= lu_rd_addr_in;
      r_mem_data[r_wptr] <= lu_data_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= AW'(r_wptr + AW'(1));
      if (w_pop)  r_rptr <= AW'(r_rptr + AW'(1));
      case ({w_push, w_pop})
        2'b10:   r_count <= CW'(r_count + CW'(1));
        2'b01:   r_count <= CW'(r_count - CW'(1));
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef WB_STARVE_GUARD_EN
  logic [3:0] r_starve;
  logic       r_stall;
  logic       w_blocked;

  assign w_blocked = ~w_empty & ~w_pop;
  assign w_stall   = r_stall;

  // Count consecutive blocked cycles; the MAX_STARVE-th one forces a one-cycle stall.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else if (w_blocked) begin
      r_starve <= 4'(r_starve + 4'd1);
      r_stall  <= (r_starve == 4'(MAX_STARVE - 1));
    end else begin
      r_starve <= '0;
      r_stall  <= 1'b0;
    end
  end
`else
  assign w_stall = 1'b0;
`endif

endmodule
